mips_regfile_mp: RTL



---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/mips_regfile_mp.sv | 76 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and popcount helper for mips_regfile_mp
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_ADR  = 0;
  // Widest register file the popcount helper covers (AW up to 8).
  localparam int MAX_DEPTH = 256;

  function automatic logic [8:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [8:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      cnt = cnt + 9'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write bits, PendCnt and per-port RBusy
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              WE,
  input  logic [AW-1:0]     WAdr,
  input  logic              IssueEn,
  input  logic [AW-1:0]     IssueAdr,
  input  logic              Flush,
  input  logic [NRD*AW-1:0] RAdr,
  output logic [NRD-1:0]    RBusy,
  output logic [AW:0]       PendCnt
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] ZADR = AW'(ZERO_ADR);

  logic [DEPTH-1:0] sb_q, sb_d;
  logic [AW:0]      pend_q, pend_d;

  // Set is applied after clear so a same-address issue keeps the bit owned.
  always_comb begin
    sb_d = sb_q;
    if (Flush) begin
      sb_d = '0;
    end else begin
      if (WE) sb_d[WAdr] = 1'b0;
      if (IssueEn && !(ZERO_REG != 0 && IssueAdr == ZADR)) sb_d[IssueAdr] = 1'b1;
    end
    pend_d = (AW+1)'(popcount(MAX_DEPTH'(sb_d)));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sb_q   <= '0;
      pend_q <= '0;
    end else begin
      sb_q   <= sb_d;
      pend_q <= pend_d;
    end
  end

  assign PendCnt = pend_q;

  for (genvar g = 0; g < NRD; g++) begin : g_busy
    logic [AW-1:0] ra;
    assign ra = RAdr[g*AW +: AW];
    assign RBusy[g] = sb_q[ra] && !(WE && WAdr == ra) && !(ZERO_REG != 0 && ra == ZADR);
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// rtl/mips_regfile_mp.sv - multi-read-port register file with bypass; scoreboard under REGFILE_SCOREBOARD_EN
module mips_regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NRD*AW-1:0] RAdr,
  output logic [NRD*DW-1:0] RData,
  input  logic              WE,
  input  logic [AW-1:0]     WAdr,
  input  logic [DW-1:0]     Din,
  input  logic              IssueEn,
  input  logic [AW-1:0]     IssueAdr,
  input  logic              Flush,
  output logic [NRD-1:0]    RBusy,
  output logic [AW:0]       PendCnt
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] ZADR = AW'(ZERO_ADR);

  logic [DW-1:0] mem_q [DEPTH];
  logic          wr_ok;

  assign wr_ok = WE && !(ZERO_REG != 0 && WAdr == ZADR);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[WAdr] <= Din;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    assign ra = RAdr[g*AW +: AW];
    always_comb begin
      rd = mem_q[ra];
      if (wr_ok && WAdr == ra) rd = Din;
      if (ZERO_REG != 0 && ra == ZADR) rd = '0;
    end
    assign RData[g*DW +: DW] = rd;
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .AW       (AW),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .Clk      (Clk),
    .Rst      (Rst),
    .WE       (WE),
    .WAdr     (WAdr),
    .IssueEn  (IssueEn),
    .IssueAdr (IssueAdr),
    .Flush    (Flush),
    .RAdr     (RAdr),
    .RBusy    (RBusy),
    .PendCnt  (PendCnt)
  );
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{IssueEn, IssueAdr, Flush};
  assign RBusy   = '0;
  assign PendCnt = '0;
`endif

endmodule
